crop_window_ctrl: RTL and testbench
===================================

# crop_window_ctrl

Runtime controller for the crop path. It owns the raster position counters and the active crop window, and accepts new window configurations over a valid/ready port. A new window is applied only at frame boundaries, so one frame never mixes two windows. It gates the incoming pixel stream into a registered output stage with backpressure and frame/line markers. It sits between the camera grabber and downstream consumers, and replaces fixed compile-time windows with per-frame-switchable ones.

## Interface
- PIXEL_BIT_WIDTH, 12, pixel width
- IN_ROWS, 40, input frame height
- IN_COLS, 40, input frame width
- DEF_Y_1, 10, reset-value window top row
- DEF_X_1, 10, reset-value window left column
- DEF_OUT_ROWS, 20, reset-value window height
- DEF_OUT_COLS, 20, reset-value window width
- Derived: RW = $clog2(IN_ROWS+1), CW = $clog2(IN_COLS+1)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- pixel_in  in  PIXEL_BIT_WIDTH  input pixel, raster order
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- pixel_out  out  PIXEL_BIT_WIDTH  cropped pixel
- out_sof / out_eol / out_eof  out  1 each  first pixel of window / last pixel of window row / last pixel of window
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high when no config is pending
- cfg_y1, cfg_rows  in  RW  requested top row and height
- cfg_x1, cfg_cols  in  CW  requested left column and width
- cfg_err  out  1  one-cycle pulse when a config is rejected
- frame_done  out  1  one-cycle pulse after the last input pixel of a frame
- frame_cnt  out  16  completed input frames, wraps at 2^16

## Operation
- FSM states:
  - S_IDLE: x=y=0, no frame in progress.
  - S_FRAME: mid-frame.
- Transitions:
  - S_IDLE→S_FRAME on the first accepted beat.
  - S_FRAME→S_IDLE on the accepted beat at x=IN_COLS-1, y=IN_ROWS-1 (the boundary).
  - x and y advance only on accepted beats. x wraps at IN_COLS-1; y wraps at IN_ROWS-1.
- Config acceptance: a config is accepted on cfg_valid && cfg_ready and is then validated.
  - Rejected if rows==0, cols==0, y1+rows>IN_ROWS or x1+cols>IN_COLS. Sums are computed at RW+1 / CW+1 bits.
  - A rejected config pulses cfg_err on the next cycle and leaves the pending slot empty.
  - An accepted valid config fills the pending slot, which drives cfg_ready low.
- Apply rule:
  - In S_IDLE, a pending config moves to the active window on the next edge.
  - On the boundary beat, the pending config (or a config accepted in that same cycle) becomes active for the next frame.
  - The pending slot then clears and cfg_ready rises.
- Keep condition for an accepted beat: y1≤y<y1+rows and x1≤x<x1+cols, evaluated against the active window. Non-kept beats are consumed and dropped.
- Markers, evaluated on kept beats:
  - sof: y==y1 && x==x1
  - eol: x==x1+cols-1
  - eof: eol && y==y1+rows-1
- frame_done pulses and frame_cnt increments one cycle after the boundary beat.

## Timing
- Reset values: out_valid=0, pixel_out=0, markers=0, cfg_err=0, frame_done=0, frame_cnt=0, cfg_ready=1, in_ready=1. State is S_IDLE, the active window holds the DEF_* values, and the pending slot is empty.
- Reset mid-frame clears state immediately. Any in-flight output beat is lost.
- Latency: a kept beat appears on pixel_out/out_valid one cycle after acceptance.
- Output stage is a single register. in_ready = out_ready || !out_valid (combinational).
- While out_valid && !out_ready, pixel_out and the markers hold stable.
- Elaboration error if any DEF_* window violates the validation rule.

## Structure
- Package crop_pkg holds:
  - RW/CW width functions
  - FSM state encoding (S_IDLE, S_FRAME)
  - a window-record typedef {y1, x1, rows, cols}
  - the window validation function
- Sub-module crop_raster_counter holds x/y with advance-enable, wrap, and an end_of_frame flag. It is reusable by other crop/ROI blocks.

## Test plan
Default parameters; pixel_in = frame pixel index.
- Reset, one 1600-beat frame, out_ready=1 → 400 outputs:
  - first output 410 with out_sof
  - 429 with out_eol
  - last output 1189 with out_eof
  - frame_done one cycle after beat 1599; frame_cnt=1.
- Config y1=0,x1=0,rows=40,cols=40 at beat 500 → cfg_ready low; current frame still yields 400 outputs; next frame yields 1600 outputs; cfg_ready high after the boundary.
- Config x1=30,cols=20 → cfg_err pulses once; active window unchanged; cfg_ready stays 1.
- out_ready low 5 cycles with out_valid=1 → pixel_out stable and in_ready low. Then 50% random out_ready over 3 frames → output matches the model with zero loss.
- Config accepted in the same cycle as beat 1599 → applied to the immediately following frame.
- Reset asserted at beat 700 → outputs zero without waiting for clk. The next frame starts at x=y=0 with the DEF window; frame_cnt=0.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop path: widths, FSM encoding, window record
// and window validation.
package crop_pkg;

  localparam int WIN_W = 16;

  typedef enum logic [0:0] {
    S_IDLE,
    S_FRAME
  } crop_state_t;

  typedef struct packed {
    logic [WIN_W-1:0] y1;
    logic [WIN_W-1:0] x1;
    logic [WIN_W-1:0] rows;
    logic [WIN_W-1:0] cols;
  } crop_win_t;

  function automatic int rw_of(input int in_rows);
    return $clog2(in_rows + 1);
  endfunction

  function automatic int cw_of(input int in_cols);
    return $clog2(in_cols + 1);
  endfunction

  // A window must be non-empty and lie entirely inside the input frame.
  function automatic logic win_valid(input crop_win_t w, input int in_rows, input int in_cols);
    logic [WIN_W:0] y_end;
    logic [WIN_W:0] x_end;
    y_end = {1'b0, w.y1} + {1'b0, w.rows};
    x_end = {1'b0, w.x1} + {1'b0, w.cols};
    return (w.rows != '0) && (w.cols != '0) &&
           (y_end <= (WIN_W+1)'(in_rows)) && (x_end <= (WIN_W+1)'(in_cols));
  endfunction

endpackage

// File: rtl/crop_raster_counter.sv
// Raster x/y position counter with advance enable, row/frame wrap and an
// end-of-frame flag for the current position.
module crop_raster_counter #(
  parameter int ROWS = 40,
  parameter int COLS = 40,
  localparam int RW = $clog2(ROWS + 1),
  localparam int CW = $clog2(COLS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [CW-1:0] x,
  output logic [RW-1:0] y,
  output logic          end_of_frame
);

  localparam logic [CW-1:0] X_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] Y_LAST = RW'(ROWS - 1);

  logic x_last;
  logic y_last;

  assign x_last       = (x == X_LAST);
  assign y_last       = (y == Y_LAST);
  assign end_of_frame = x_last && y_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + RW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crop_window_ctrl.sv
// Crop controller: raster tracking, frame-boundary window switching from a
// valid/ready config port, and a single-register gated output stage.
module crop_window_ctrl
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int DEF_Y_1         = 10,
  parameter int DEF_X_1         = 10,
  parameter int DEF_OUT_ROWS    = 20,
  parameter int DEF_OUT_COLS    = 20,
  localparam int RW = rw_of(IN_ROWS),
  localparam int CW = cw_of(IN_COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [RW-1:0]              cfg_y1,
  input  logic [RW-1:0]              cfg_rows,
  input  logic [CW-1:0]              cfg_x1,
  input  logic [CW-1:0]              cfg_cols,
  output logic                       cfg_err,
  output logic                       frame_done,
  output logic [15:0]                frame_cnt
);

  localparam crop_win_t DEF_WIN = '{
    y1:   WIN_W'(DEF_Y_1),
    x1:   WIN_W'(DEF_X_1),
    rows: WIN_W'(DEF_OUT_ROWS),
    cols: WIN_W'(DEF_OUT_COLS)
  };

  if (!win_valid(DEF_WIN, IN_ROWS, IN_COLS)) begin : g_bad_def_window
    $error("crop_window_ctrl: default window does not fit the input frame");
  end

  crop_state_t state, state_nxt;
  crop_win_t   act_win, pend_win, cfg_win;
  logic        pend_v;

  logic [CW-1:0] x;
  logic [RW-1:0] y;
  logic          eof_pos;

  logic acc, cfg_fire, cfg_good;
  logic boundary, apply_pend, apply_cfg;

  logic [WIN_W-1:0] xe, ye, x_end, y_end;
  logic             keep, at_sof, at_eol, at_eof;

  assign in_ready  = out_ready || !out_valid;
  assign acc       = in_valid && in_ready;
  assign cfg_ready = !pend_v;
  assign cfg_fire  = cfg_valid && cfg_ready;

  assign cfg_win = '{
    y1:   WIN_W'(cfg_y1),
    x1:   WIN_W'(cfg_x1),
    rows: WIN_W'(cfg_rows),
    cols: WIN_W'(cfg_cols)
  };
  assign cfg_good = win_valid(cfg_win, IN_ROWS, IN_COLS);

  crop_raster_counter #(
    .ROWS(IN_ROWS),
    .COLS(IN_COLS)
  ) u_raster (
    .clk          (clk),
    .reset        (reset),
    .adv          (acc),
    .x            (x),
    .y            (y),
    .end_of_frame (eof_pos)
  );

  assign xe    = WIN_W'(x);
  assign ye    = WIN_W'(y);
  assign y_end = act_win.y1 + act_win.rows;
  assign x_end = act_win.x1 + act_win.cols;

  assign keep   = (ye >= act_win.y1) && (ye < y_end) && (xe >= act_win.x1) && (xe < x_end);
  assign at_sof = (ye == act_win.y1) && (xe == act_win.x1);
  assign at_eol = (xe == x_end - WIN_W'(1));
  assign at_eof = at_eol && (ye == y_end - WIN_W'(1));

  always_comb begin
    state_nxt  = state;
    boundary   = 1'b0;
    apply_pend = 1'b0;
    apply_cfg  = 1'b0;
    case (state)
      S_IDLE: begin
        // An idle-time apply is deferred if a frame starts on this edge, so
        // the first beat and the rest of the frame see the same window.
        if (acc) state_nxt = S_FRAME;
        else     apply_pend = pend_v;
      end
      S_FRAME: begin
        if (acc && eof_pos) begin
          state_nxt  = S_IDLE;
          boundary   = 1'b1;
          apply_pend = pend_v;
          apply_cfg  = cfg_fire && cfg_good;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_win  <= DEF_WIN;
      pend_win <= '0;
      pend_v   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && !cfg_good;
      if (apply_pend) begin
        act_win <= pend_win;
        pend_v  <= 1'b0;
      end else if (apply_cfg) begin
        act_win <= cfg_win;
      end else if (cfg_fire && cfg_good) begin
        pend_win <= cfg_win;
        pend_v   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= boundary;
      if (boundary) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (acc) begin
      out_valid <= keep;
      out_sof   <= keep && at_sof;
      out_eol   <= keep && at_eol;
      out_eof   <= keep && at_eof;
      if (keep) pixel_out <= pixel_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Directed bench for crop_window_ctrl: frame streaming, config switching and
// rejection, backpressure, and asynchronous reset mid-frame.
module tb_crop_window_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] pixel_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] pixel_out;
  logic        out_sof, out_eol, out_eof;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [5:0]  cfg_y1 = '0, cfg_rows = '0, cfg_x1 = '0, cfg_cols = '0;
  logic        cfg_err;
  logic        frame_done;
  logic [15:0] frame_cnt;

  crop_window_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_y1     (cfg_y1),
    .cfg_rows   (cfg_rows),
    .cfg_x1     (cfg_x1),
    .cfg_cols   (cfg_cols),
    .cfg_err    (cfg_err),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y1;
    int x1;
    int rows;
    int cols;
  } wexp_t;

  localparam wexp_t W_DEF   = '{10, 10, 20, 20};
  localparam wexp_t W_FULL  = '{0, 0, 40, 40};
  localparam wexp_t W_SMALL = '{5, 3, 4, 6};

  wexp_t wq[$];
  int errors = 0, checks = 0;
  int idx = 0, k = 0, n_out = 0, first_pix = 0, last_pix = 0;
  int cfg_at = -1, stall_at = -1, stall_left = 0, or_mode = 0, exp_fc = 0;
  bit cfg_sent = 1'b0, c_bad = 1'b0, send = 1'b0;
  bit exp_fd = 1'b0, exp_err = 1'b0, frame_end = 1'b0;
  logic [5:0] c_y1 = '0, c_rows = '0, c_x1 = '0, c_cols = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out();
    wexp_t w;
    int r, c, pix;
    if (wq.size() == 0) begin
      check("unexpected_out", 32'(pixel_out), 32'hFFFF_FFFF);
      return;
    end
    w   = wq[0];
    r   = k / w.cols;
    c   = k % w.cols;
    pix = (w.y1 + r) * 40 + w.x1 + c;
    check("pix", 32'(pixel_out), pix);
    check("markers", 32'({out_sof, out_eol, out_eof}),
          32'({k == 0, c == w.cols - 1, k == w.rows * w.cols - 1}));
    if (n_out == 0) first_pix = int'(pixel_out);
    last_pix = int'(pixel_out);
    n_out++;
    k++;
    if (k == w.rows * w.cols) begin
      k = 0;
      void'(wq.pop_front());
    end
  endtask

  task automatic set_cfg(input int y1, input int x1, input int rows, input int cols,
                         input int at, input bit bad);
    c_y1 = 6'(y1); c_x1 = 6'(x1); c_rows = 6'(rows); c_cols = 6'(cols);
    cfg_at = at; c_bad = bad; cfg_sent = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
    in_valid  = send;
    pixel_in  = 12'(idx);
    cfg_valid = (idx == cfg_at) && !cfg_sent;
    cfg_y1 = c_y1; cfg_x1 = c_x1; cfg_rows = c_rows; cfg_cols = c_cols;
    if (stall_left > 0 && idx == stall_at) out_ready = 1'b0;
    else if (or_mode == 1)                 out_ready = 1'($urandom_range(0, 1));
    else                                   out_ready = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (exp_fd) begin
      exp_fc++;
      check("frame_cnt", 32'(frame_cnt), exp_fc);
    end
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    exp_fd  = 1'b0;
    exp_err = 1'b0;
    if (!out_ready && stall_left > 0) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_pix", 32'(pixel_out), stall_at - 1);
      stall_left--;
    end
    if (out_valid && out_ready) check_out();
    if (cfg_valid) begin
      check("cfg_ready_offer", 32'(cfg_ready), 1);
      if (cfg_ready) begin
        cfg_sent = 1'b1;
        exp_err  = c_bad;
      end
    end
    if (in_valid && in_ready) begin
      if (idx == 1599) begin
        idx = 0;
        exp_fd = 1'b1;
        frame_end = 1'b1;
      end else begin
        idx++;
      end
    end
  endtask

  task automatic send_frame(input int stop);
    int n;
    bit done;
    send = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 12000) begin
      cycle();
      n++;
      if (frame_end) done = 1'b1;
      if (stop >= 0 && idx == stop) done = 1'b1;
    end
    if (!done) check("frame_timeout", 32'(n), 0);
  endtask

  task automatic drain();
    int n;
    send = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (out_valid && n < 400);
    check("drained", 32'(out_valid), 0);
  endtask

  task automatic frame_outs(input string tag, input int exp);
    check(tag, n_out, exp);
    n_out = 0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_pixel_out", 32'(pixel_out), 0);
    check("rst_markers", 32'({out_sof, out_eol, out_eof}), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (3) cycle();
    reset = 1'b0;

    // Frame 1: default window, no backpressure.
    wq.push_back(W_DEF);
    send_frame(-1);
    drain();
    check("f1_first", first_pix, 410);
    check("f1_last", last_pix, 1189);
    check("f1_frame_cnt", 32'(frame_cnt), 1);
    frame_outs("f1_outs", 400);

    // Full-frame config offered mid-frame takes effect on the next frame only.
    set_cfg(0, 0, 40, 40, 500, 1'b0);
    wq.push_back(W_DEF);
    send_frame(-1);
    check("cfg_pending", 32'(cfg_ready), 0);
    drain();
    check("cfg_ready_after", 32'(cfg_ready), 1);
    frame_outs("f2_outs", 400);
    wq.push_back(W_FULL);
    send_frame(-1);
    drain();
    frame_outs("f3_outs", 1600);

    // Restore the default window while idle, then offer an out-of-range one.
    set_cfg(10, 10, 20, 20, 0, 1'b0);
    repeat (3) cycle();
    check("idle_apply_ready", 32'(cfg_ready), 1);
    set_cfg(0, 30, 10, 20, 0, 1'b1);
    repeat (3) cycle();
    check("bad_cfg_ready", 32'(cfg_ready), 1);

    // Stall output for 5 cycles while holding pixel 414.
    stall_at = 415;
    stall_left = 5;
    wq.push_back(W_DEF);
    send_frame(-1);
    drain();
    check("stall_done", stall_left, 0);
    frame_outs("f4_outs", 400);

    or_mode = 1;
    for (int f = 0; f < 3; f++) begin
      wq.push_back(W_DEF);
      send_frame(-1);
      drain();
      frame_outs("rand_outs", 400);
    end
    or_mode = 0;

    // Config accepted together with the boundary beat.
    set_cfg(5, 3, 4, 6, 1599, 1'b0);
    wq.push_back(W_DEF);
    send_frame(-1);
    drain();
    check("same_cycle_sent", 32'(cfg_sent), 1);
    frame_outs("f8_outs", 400);
    wq.push_back(W_SMALL);
    send_frame(-1);
    drain();
    check("f9_first", first_pix, 203);
    frame_outs("f9_outs", 24);

    set_cfg(10, 10, 20, 20, 0, 1'b0);
    repeat (3) cycle();

    // Asynchronous reset in the middle of a frame.
    wq.push_back(W_DEF);
    send_frame(700);
    check("pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_pixel_out", 32'(pixel_out), 0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    wq.delete();
    k = 0; n_out = 0; idx = 0; exp_fc = 0; exp_fd = 1'b0; exp_err = 1'b0;
    send = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    wq.push_back(W_DEF);
    send_frame(-1);
    drain();
    check("post_rst_first", first_pix, 410);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);
    frame_outs("post_rst_outs", 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
